// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a combinational barrel shifter through a programmed
// sweep of shift amounts and directions at a prescaled step rate. It captures
// the switch operand on start, latches each shifter result for the LEDs, and
// reports progress (step_strobe), activity (busy) and completion (done).
module shift_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int SHAMT_W    = 2,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                  FPGA_CLK,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  repeat_i,
    input  logic [DATA_WIDTH-1:0] data_sw,
    input  logic [DATA_WIDTH-1:0] sh_result,
    output logic [DATA_WIDTH-1:0] sh_data,
    output logic [SHAMT_W-1:0]    sh_amount,
    output logic                  sh_dir,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  step_strobe,
    output logic                  busy,
    output logic                  done
);

    // Tick counter needs at least one bit even when TICK_DIV = 1.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SHAMT_W-1:0] AMT_MAX   = SHAMT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [CNT_W-1:0]      tick_q,     tick_d;
    logic                  leg_q,      leg_d;
    logic                  pingpong_q, pingpong_d;
    logic [DATA_WIDTH-1:0] sh_data_q,  sh_data_d;
    logic [SHAMT_W-1:0]    amount_q,   amount_d;
    logic                  dir_q,      dir_d;
    logic [DATA_WIDTH-1:0] result_q,   result_d;
    logic                  strobe_q,   strobe_d;
    logic                  step;

    // A step happens on the edge that closes the last tick of the interval.
    assign step = (tick_q == TICK_LAST);

    // Next-state logic: operand capture in LOAD, amount/direction walk in RUN.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        leg_d      = leg_q;
        pingpong_d = pingpong_q;
        sh_data_d  = sh_data_q;
        amount_d   = amount_q;
        dir_d      = dir_q;
        result_d   = result_q;
        strobe_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sh_data_d  = data_sw;
                amount_d   = '0;
                dir_d      = mode[0];
                pingpong_d = mode[1];
                tick_d     = '0;
                leg_d      = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (step) begin
                    tick_d   = '0;
                    result_d = sh_result;
                    strobe_d = 1'b1;
                    if (amount_q < AMT_MAX) begin
                        amount_d = amount_q + 1'b1;
                    end else if (pingpong_q && !leg_q) begin
                        // Second leg: restart the sweep in the opposite direction.
                        amount_d = '0;
                        dir_d    = ~dir_q;
                        leg_d    = 1'b1;
                    end else begin
                        // Last step of the pass; repeat reloads without a done pulse.
                        state_d = repeat_i ? S_LOAD : S_DONE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sequence and clears every output.
    always_ff @(posedge FPGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            leg_q      <= 1'b0;
            pingpong_q <= 1'b0;
            sh_data_q  <= '0;
            amount_q   <= '0;
            dir_q      <= 1'b0;
            result_q   <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            leg_q      <= leg_d;
            pingpong_q <= pingpong_d;
            sh_data_q  <= sh_data_d;
            amount_q   <= amount_d;
            dir_q      <= dir_d;
            result_q   <= result_d;
            strobe_q   <= strobe_d;
        end
    end

    assign sh_data     = sh_data_q;
    assign sh_amount   = amount_q;
    assign sh_dir      = dir_q;
    assign result      = result_q;
    assign step_strobe = strobe_q;
    // Status decoded straight from the state register, so no combinational inputs.
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a logical-shift shifter model.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       rpt;
    logic [3:0] data_sw;
    logic [3:0] sh_result;
    logic [3:0] sh_data;
    logic [1:0] sh_amount;
    logic       sh_dir;
    logic [3:0] result;
    logic       step_strobe;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    // Per-run log of what the DUT produced
    logic [3:0] sv[16];
    int         sc[16];
    logic       sd[16];
    int         ns;
    int         nd;
    int         dc;
    int         bc;
    logic [3:0] exp_res[8];

    shift_sequencer #(
        .DATA_WIDTH(4),
        .SHAMT_W   (2),
        .TICK_DIV  (4)
    ) dut (
        .FPGA_CLK   (clk),
        .RESET_N    (rst_n),
        .start      (start),
        .mode       (mode),
        .repeat_i   (rpt),
        .data_sw    (data_sw),
        .sh_result  (sh_result),
        .sh_data    (sh_data),
        .sh_amount  (sh_amount),
        .sh_dir     (sh_dir),
        .result     (result),
        .step_strobe(step_strobe),
        .busy       (busy),
        .done       (done)
    );

    // Logical barrel shifter model
    assign sh_result = sh_dir ? (sh_data >> sh_amount) : (sh_data << sh_amount);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_log();
        for (int i = 0; i < 16; i++) begin
            sv[i] = 'x;
            sc[i] = -1;
            sd[i] = 1'bx;
        end
        ns = 0;
        nd = 0;
        dc = -1;
        bc = 0;
    endtask

    // Advance to the next falling edge and log strobes, done and busy
    task automatic tick_log(input int c);
        @(negedge clk);
        if (step_strobe && ns < 16) begin
            sv[ns] = result;
            sc[ns] = c;
            sd[ns] = sh_dir;
            ns++;
        end
        if (done) begin
            dc = c;
            nd++;
        end
        if (busy) bc++;
    endtask

    task automatic begin_run(input logic [3:0] d, input logic [1:0] m);
        @(negedge clk);
        data_sw = d;
        mode    = m;
        start   = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sh_data, sh_amount, sh_dir, result, step_strobe, busy, done} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0",
                     {sh_data, sh_amount, sh_dir, result, step_strobe, busy, done});
        end
        rst_n = 1'b1;
        clear_log();
        for (int c = 0; c < 4; c++) tick_log(c);
        n_checks++;
        if (ns !== 0 || nd !== 0 || bc !== 0) begin
            n_fail++;
            $display("FAIL reset_release_idle: strobes=%0d dones=%0d busy_cycles=%0d required 0/0/0",
                     ns, nd, bc);
        end
        $display("reset: done");
    endtask

    task automatic test_left_sweep();
        exp_res[0] = 4'b0011; exp_res[1] = 4'b0110;
        exp_res[2] = 4'b1100; exp_res[3] = 4'b1000;
        begin_run(4'b0011, 2'b00);
        for (int c = 0; c < 26; c++) begin
            tick_log(c);
            if (c == 0) begin
                start = 1'b0;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_busy_rise: got %b required 1", busy);
                end
            end
        end
        n_checks++;
        if (ns !== 4) begin
            n_fail++;
            $display("FAIL sweep_strobe_count: got %0d required 4", ns);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sv[i] !== exp_res[i] || sc[i] !== 5 + 4 * i) begin
                n_fail++;
                $display("FAIL sweep_step%0d: got %b at cycle %0d required %b at cycle %0d",
                         i + 1, sv[i], sc[i], exp_res[i], 5 + 4 * i);
            end
        end
        n_checks++;
        if (nd !== 1 || dc !== 17) begin
            n_fail++;
            $display("FAIL sweep_done: got %0d pulses at cycle %0d required 1 at 17", nd, dc);
        end
        n_checks++;
        if (bc !== 18) begin
            n_fail++;
            $display("FAIL sweep_busy_len: got %0d required 18", bc);
        end
        $display("left sweep: %0d strobes, done at cycle %0d", ns, dc);
    endtask

    task automatic test_pingpong();
        exp_res[0] = 4'b1000; exp_res[1] = 4'b0100;
        exp_res[2] = 4'b0010; exp_res[3] = 4'b0001;
        exp_res[4] = 4'b1000; exp_res[5] = 4'b0000;
        exp_res[6] = 4'b0000; exp_res[7] = 4'b0000;
        begin_run(4'b1000, 2'b11);
        for (int c = 0; c < 40; c++) begin
            tick_log(c);
            if (c == 0) start = 1'b0;
        end
        n_checks++;
        if (ns !== 8) begin
            n_fail++;
            $display("FAIL pingpong_strobe_count: got %0d required 8", ns);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            // direction seen after each step: flips on the edge of step 4
            if (sv[i] !== exp_res[i] || sc[i] !== 5 + 4 * i || sd[i] !== (i < 3)) begin
                n_fail++;
                $display("FAIL pingpong_step%0d: got %b dir %b cycle %0d required %b dir %b cycle %0d",
                         i + 1, sv[i], sd[i], sc[i], exp_res[i], (i < 3), 5 + 4 * i);
            end
        end
        n_checks++;
        if (nd !== 1 || dc !== 33 || bc !== 34) begin
            n_fail++;
            $display("FAIL pingpong_done: got %0d pulses at %0d busy %0d required 1 at 33 busy 34",
                     nd, dc, bc);
        end
        $display("ping-pong: %0d strobes, done at cycle %0d", ns, dc);
    endtask

    task automatic test_ignore_busy();
        exp_res[0] = 4'b0011; exp_res[1] = 4'b0110;
        exp_res[2] = 4'b1100; exp_res[3] = 4'b1000;
        begin_run(4'b0011, 2'b00);
        for (int c = 0; c < 30; c++) begin
            tick_log(c);
            if (c == 0) start = 1'b0;
            if (c == 3) begin
                start   = 1'b1;
                data_sw = 4'b1111;
                mode    = 2'b01;
            end
            if (c == 8) start = 1'b0;
            if (c == 10) begin
                n_checks++;
                if (sh_data !== 4'b0011 || sh_dir !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_operand: got data %b dir %b required 0011 dir 0",
                             sh_data, sh_dir);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sv[i] !== exp_res[i] || sc[i] !== 5 + 4 * i) begin
                n_fail++;
                $display("FAIL ignore_step%0d: got %b at cycle %0d required %b at cycle %0d",
                         i + 1, sv[i], sc[i], exp_res[i], 5 + 4 * i);
            end
        end
        n_checks++;
        if (ns !== 4 || nd !== 1 || dc !== 17 || bc !== 18) begin
            n_fail++;
            $display("FAIL ignore_single_run: strobes %0d dones %0d at %0d busy %0d required 4 1 17 18",
                     ns, nd, dc, bc);
        end
        data_sw = 4'b0000;
        mode    = 2'b00;
        $display("ignore during busy: %0d strobes, busy %0d cycles", ns, bc);
    endtask

    task automatic test_repeat();
        exp_res[0] = 4'b0011; exp_res[1] = 4'b0110;
        exp_res[2] = 4'b1100; exp_res[3] = 4'b1000;
        exp_res[4] = 4'b0101; exp_res[5] = 4'b1010;
        exp_res[6] = 4'b0100; exp_res[7] = 4'b1000;
        begin_run(4'b0011, 2'b00);
        for (int c = 0; c < 42; c++) begin
            tick_log(c);
            if (c == 0) start = 1'b0;
            if (c == 14) begin
                rpt     = 1'b1;
                data_sw = 4'b0101;
            end
            if (c == 20) rpt = 1'b0;
            if (c == 18) begin
                n_checks++;
                if (sh_data !== 4'b0101 || sh_amount !== 2'd0 || nd !== 0) begin
                    n_fail++;
                    $display("FAIL repeat_reload: got data %b amount %0d dones %0d required 0101 0 0",
                             sh_data, sh_amount, nd);
                end
            end
        end
        n_checks++;
        if (ns !== 8) begin
            n_fail++;
            $display("FAIL repeat_strobe_count: got %0d required 8", ns);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (sv[i] !== exp_res[i] || sc[i] !== ((i < 4) ? 5 + 4 * i : 22 + 4 * (i - 4))) begin
                n_fail++;
                $display("FAIL repeat_step%0d: got %b at cycle %0d required %b at cycle %0d",
                         i + 1, sv[i], sc[i], exp_res[i], (i < 4) ? 5 + 4 * i : 22 + 4 * (i - 4));
            end
        end
        n_checks++;
        if (nd !== 1 || dc !== 34 || bc !== 35) begin
            n_fail++;
            $display("FAIL repeat_done: got %0d pulses at %0d busy %0d required 1 at 34 busy 35",
                     nd, dc, bc);
        end
        $display("repeat: %0d strobes, done at cycle %0d", ns, dc);
    endtask

    task automatic test_midrun_reset();
        exp_res[0] = 4'b1001; exp_res[1] = 4'b0100;
        exp_res[2] = 4'b0010; exp_res[3] = 4'b0001;
        begin_run(4'b0011, 2'b00);
        for (int c = 0; c < 11; c++) begin
            tick_log(c);
            if (c == 0) start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sh_data, sh_amount, sh_dir, result, step_strobe, busy, done} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_async: got %b required 0",
                     {sh_data, sh_amount, sh_dir, result, step_strobe, busy, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int c = 0; c < 8; c++) tick_log(c);
        n_checks++;
        if (ns !== 0 || nd !== 0 || bc !== 0) begin
            n_fail++;
            $display("FAIL midrun_after_release: strobes %0d dones %0d busy %0d required 0 0 0",
                     ns, nd, bc);
        end
        begin_run(4'b1001, 2'b01);
        for (int c = 0; c < 24; c++) begin
            tick_log(c);
            if (c == 0) start = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sv[i] !== exp_res[i] || sc[i] !== 5 + 4 * i) begin
                n_fail++;
                $display("FAIL rerun_step%0d: got %b at cycle %0d required %b at cycle %0d",
                         i + 1, sv[i], sc[i], exp_res[i], 5 + 4 * i);
            end
        end
        n_checks++;
        if (ns !== 4 || nd !== 1 || dc !== 17 || bc !== 18) begin
            n_fail++;
            $display("FAIL rerun_done: strobes %0d dones %0d at %0d busy %0d required 4 1 17 18",
                     ns, nd, dc, bc);
        end
        $display("mid-run reset: rerun %0d strobes, done at cycle %0d", ns, dc);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        rpt      = 1'b0;
        data_sw  = 4'b0000;
        test_reset();
        test_left_sweep();
        test_pingpong();
        test_ignore_busy();
        test_repeat();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing controller for the board-level barrel shifter. It captures the DIP-switch operand on a start request and walks the shifter through a programmed sweep of shift amounts and directions at a prescaled step rate. It registers each shifter result for the LEDs and signals progress and completion. It sits between the top-level switch/LED pins and the combinational barrel shifter instance, replacing the fixed shift constants.

## Interface
- DATA_WIDTH, 4: operand width. Must be a power of two, ≥ 2.
- SHAMT_W, 2: shift-amount width. Must equal clog2(DATA_WIDTH).
- TICK_DIV, 50_000_000: clock cycles per step, ≥ 1. The bench overrides it to a small value.

- FPGA_CLK  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- start  in  1  start request; sampled only in IDLE.
- mode  in  2  sequence select:
  - mode[0] is the initial direction (0 = left, 1 = right).
  - mode[1] = 1 selects ping-pong: the direction flips after the first leg.
- repeat  in  1  sampled at the last step; 1 = reload and rerun instead of finishing.
- data_sw  in  DATA_WIDTH  operand source (switches).
- sh_result  in  DATA_WIDTH  combinational output of the shifter.
- sh_data  out  DATA_WIDTH  registered operand to the shifter.
- sh_amount  out  SHAMT_W  registered shift amount to the shifter.
- sh_dir  out  1  registered direction to the shifter.
- result  out  DATA_WIDTH  latched shifter result (LED drive).
- step_strobe  out  1  one-cycle pulse whenever result updates.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence completion.

## Operation
- States and transitions:
  - IDLE: waits for start; goes to LOAD when start = 1.
  - LOAD: lasts one cycle.
    - sh_data ← data_sw, sh_amount ← 0, sh_dir ← mode[0].
    - Clears the tick counter and the leg flag.
    - Goes to RUN.
  - RUN: the tick counter counts 0..TICK_DIV-1 and wraps. The edge on which count == TICK_DIV-1 is a step edge. On each step edge:
    - result ← sh_result and step_strobe ← 1. sh_data, sh_amount and sh_dir have been stable for the whole interval.
    - If sh_amount < DATA_WIDTH-1, sh_amount increments.
    - Else, if mode[1] = 1 and leg = 0: sh_amount ← 0, sh_dir ← ~sh_dir, leg ← 1.
    - Else (last step): go to LOAD if repeat = 1 (new data_sw captured, no done pulse), otherwise go to DONE.
  - DONE: one cycle with done = 1, then IDLE.
- Steps per pass: DATA_WIDTH for a sweep, 2·DATA_WIDTH for ping-pong.
- mode is sampled in LOAD only. Changes to mode or data_sw during RUN have no effect.
- start during LOAD, RUN or DONE is ignored and is not queued. A start held high through DONE is accepted on the first IDLE cycle.
- sh_amount never exceeds DATA_WIDTH-1. There is no arithmetic wrap; the reload to 0 is explicit.
- Outputs keep their values in IDLE. result holds the last step's value.

## Timing
- Reset (asynchronous, takes effect immediately) clears everything to IDLE with all outputs 0: sh_data, sh_amount, sh_dir, result, step_strobe, busy, done, tick counter and leg flag.
- A reset mid-RUN aborts the sequence with no done pulse. After release the block is in IDLE.
- Cycle timing with start sampled high at edge N:
  - busy = 1 from N.
  - LOAD occupies the cycle from N to N+1; RUN begins at N+1.
  - Step k (k = 1..) occurs at edge N+1+k·TICK_DIV.
  - result and step_strobe are valid in the cycle following each step edge.
- The last step edge enters DONE. The done pulse coincides with the last step_strobe, and busy falls one cycle later.
- A repeat reload inserts one LOAD cycle between passes, so the next pass's first step comes TICK_DIV+1 cycles after the previous last step.
- With TICK_DIV = 1 a step occurs on every RUN cycle.

## Test plan
All scenarios use DATA_WIDTH = 4, TICK_DIV = 4 and a logical-shift model of the shifter.

- Reset: hold RESET_N = 0 for 3 cycles → all outputs 0, busy = 0. Release → still idle with no pulses.
- Left sweep: mode = 00, data_sw = 0011, start pulse → results 0011, 0110, 1100, 1000 at 4-cycle spacing. done pulses with the 4th strobe. busy is high for 18 cycles.
- Ping-pong from right: mode = 11, data_sw = 1000 → 8 strobes with results 1000, 0100, 0010, 0001, 1000, 0000, 0000, 0000. sh_dir flips after strobe 4. Single done pulse.
- Ignore during busy: mid-RUN, toggle start and change data_sw to 1111 and mode to 01 → sh_data, sh_dir and the sequence are unchanged. No second run is started.
- Repeat: repeat = 1 with data_sw changed to 0101 before the 4th step → LOAD recaptures 0101 with no done. Next pass results are 0101, 1010, 0100, 1000. Drop repeat → done after that pass.
- Mid-run reset: assert RESET_N = 0 between edges after strobe 2 → outputs 0 immediately. After release: IDLE, no done, and a new start runs a full sequence correctly.
